// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: a shadow-latched hex value is scanned one digit
// per slot. Each slot opens with an all-off guard interval so that digit changes never ghost.
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 500,
  parameter int BLINK_DIV = 25
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   DIN,
  input  logic                  LOAD,
  input  logic [DIGITS-1:0]     EN,
  input  logic [DIGITS-1:0]     BLINK,
  input  logic                  LZB,
  output logic [6:0]            HEX,
  output logic [DIGITS-1:0]     DIG,
  output logic                  SCAN_TICK
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [4*DIGITS-1:0] shadow;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       index;
  logic [BW-1:0]       blink_cnt;
  logic                blink_on;

  logic                slot_end;
  logic                round_end;
  logic [3:0]          nib;
  logic                en_sel;
  logic                blink_sel;
  logic                lz_sel;
  logic [DIGITS-1:0]   lz;
  logic                visible;
  logic [6:0]          hex_next;
  logic [DIGITS-1:0]   dig_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1011000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_end  = (presc == PW'(SCAN_DIV - 1));
  assign round_end = slot_end && (index == IW'(DIGITS - 1));

  // lz[i] is set when every nibble from the top digit down to i is zero
  always_comb begin
    logic run;
    run = 1'b1;
    lz  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run   = run && (shadow[4*i +: 4] == 4'h0);
      lz[i] = run;
    end
  end

  always_comb begin
    nib       = 4'h0;
    en_sel    = 1'b0;
    blink_sel = 1'b0;
    lz_sel    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (index == IW'(i)) begin
        nib       = shadow[4*i +: 4];
        en_sel    = EN[i];
        blink_sel = BLINK[i];
        lz_sel    = lz[i];
      end
    end
  end

  assign visible = en_sel && !(blink_sel && !blink_on) &&
                   !(LZB && (index != '0) && lz_sel);

  always_comb begin
    hex_next = 7'b1111111;
    dig_next = '1;
    if (presc >= PW'(GUARD)) begin
      dig_next = ~(DIGITS'(1) << index);
      if (visible) hex_next = seg_decode(nib);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow    <= '0;
      presc     <= '0;
      index     <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      HEX       <= 7'b1111111;
      DIG       <= '1;
      SCAN_TICK <= 1'b0;
    end else begin
      if (LOAD) shadow <= DIN;
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) index <= round_end ? '0 : index + 1'b1;
      SCAN_TICK <= round_end;
      if (round_end) begin
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      HEX <= hex_next;
      DIG <= dig_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: an arithmetic model derived from the elapsed cycle count is
// compared on every cycle, and a set of directed literal checks pins that model down.
module tb_seg7_scan_driver;
  localparam int D = 4, SD = 4, G = 1, BD = 2;

  logic        CLK = 1'b0;
  logic        RST, LOAD, LZB;
  logic [15:0] DIN;
  logic [3:0]  EN, BLINK;
  logic [6:0]  HEX;
  logic [3:0]  DIG;
  logic        SCAN_TICK;

  always #5 CLK = ~CLK;

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .GUARD(G), .BLINK_DIV(BD)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .LOAD(LOAD), .EN(EN), .BLINK(BLINK), .LZB(LZB),
    .HEX(HEX), .DIG(DIG), .SCAN_TICK(SCAN_TICK)
  );

  int total = 0, passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  logic [6:0] seg_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // k counts clock edges since reset released; the scan position follows from it directly
  int          k = 0;
  logic [15:0] m_shadow = '0;
  logic [6:0]  exp_hex;
  logic [3:0]  exp_dig;
  logic        exp_tick;
  logic        armed = 1'b0;

  always @(posedge CLK) begin
    int p, idx, rounds;
    logic on, vis;
    armed = 1'b1;
    if (RST) begin
      k = 0; m_shadow = '0;
      exp_hex = 7'h7F; exp_dig = 4'hF; exp_tick = 1'b0;
    end else begin
      p      = k % SD;
      idx    = (k / SD) % D;
      rounds = k / (SD * D);
      on     = ((rounds / BD) % 2) == 0;
      exp_tick = (k % (SD * D)) == (SD * D - 1);
      exp_hex = 7'h7F;
      exp_dig = 4'hF;
      if (p >= G) begin
        exp_dig = ~(4'b0001 << idx);
        vis = EN[idx] && !(BLINK[idx] && !on) && !(LZB && idx != 0 && (m_shadow >> (4 * idx)) == 16'h0);
        if (vis) exp_hex = seg_tbl[(m_shadow >> (4 * idx)) & 16'hF];
      end
      if (LOAD) m_shadow = DIN;
      k++;
    end
  end

  logic [3:0] prev_dig = 4'hF;
  logic [6:0] prev_hex = 7'h7F;

  always @(negedge CLK) begin
    if (armed) begin
      check("hex", HEX, exp_hex);
      check("dig", DIG, exp_dig);
      check("scan_tick", SCAN_TICK, exp_tick);
      check("dig_single_low", ($countones(~DIG) <= 1), 1);
      if (DIG !== prev_dig)
        check("no_ghost", ((prev_dig == 4'hF && prev_hex == 7'h7F) || (DIG == 4'hF && HEX == 7'h7F)), 1);
      prev_dig = DIG;
      prev_hex = HEX;
    end
  end

  task automatic wait_dig(input logic [3:0] target);
    int n = 0;
    while (DIG !== target && n < 64) begin
      @(negedge CLK);
      n++;
    end
    check("wait_dig", DIG, target);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int n;
    RST = 1'b1; LOAD = 1'b0; DIN = 16'h0; EN = 4'hF; BLINK = 4'h0; LZB = 1'b0;
    cycles(2);
    check("reset_hex", HEX, 7'b1111111);
    check("reset_dig", DIG, 4'b1111);
    check("reset_tick", SCAN_TICK, 1'b0);

    // plain scan of 12AF
    RST = 1'b0; LOAD = 1'b1; DIN = 16'h12AF;
    cycles(1);
    LOAD = 1'b0;
    wait_dig(4'b1110); check("d0_F", HEX, 7'b0001110);
    wait_dig(4'b1101); check("d1_A", HEX, 7'b0001000);
    wait_dig(4'b1011); check("d2_2", HEX, 7'b0100100);
    wait_dig(4'b0111); check("d3_1", HEX, 7'b1111001);
    n = 0;
    while (!SCAN_TICK && n < 40) begin @(negedge CLK); n++; end
    check("tick_seen", SCAN_TICK, 1'b1);
    n = 0;
    do begin @(negedge CLK); n++; end while (!SCAN_TICK && n < 40);
    check("tick_period", n, 16);

    // leading-zero blanking
    LZB = 1'b1; LOAD = 1'b1; DIN = 16'h0040;
    cycles(1);
    LOAD = 1'b0;
    cycles(20);
    wait_dig(4'b1101); check("lz_d1", HEX, 7'b0011001);
    wait_dig(4'b1011); check("lz_d2", HEX, 7'b1111111);
    wait_dig(4'b0111); check("lz_d3", HEX, 7'b1111111);
    wait_dig(4'b1110); check("lz_d0", HEX, 7'b1000000);
    LOAD = 1'b1; DIN = 16'h0000;
    cycles(1);
    LOAD = 1'b0;
    cycles(20);
    wait_dig(4'b1101); check("zero_d1", HEX, 7'b1111111);
    wait_dig(4'b1110); check("zero_d0", HEX, 7'b1000000);

    // blink on digit 0
    LZB = 1'b0; BLINK = 4'b0001; LOAD = 1'b1; DIN = 16'h8888;
    cycles(1);
    LOAD = 1'b0;
    cycles(140);

    // per-digit enable
    BLINK = 4'b0000; EN = 4'b1010;
    cycles(40);
    wait_dig(4'b1110); check("en_d0", HEX, 7'b1111111);
    wait_dig(4'b1101); check("en_d1", HEX, 7'b0000000);
    wait_dig(4'b1011); check("en_d2", HEX, 7'b1111111);

    // DIN without LOAD is ignored
    DIN = 16'h1234;
    cycles(20);
    wait_dig(4'b0111); check("noload_d3", HEX, 7'b0000000);

    // reset during digit 2's slot
    wait_dig(4'b1011);
    RST = 1'b1;
    cycles(1);
    check("midrst_hex", HEX, 7'b1111111);
    check("midrst_dig", DIG, 4'b1111);
    RST = 1'b0;
    n = 0;
    do begin @(negedge CLK); n++; end while (DIG === 4'hF && n < 10);
    check("post_rst_delay", n, 2);
    check("post_rst_digit", DIG, 4'b1110);
    cycles(20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
